mdu_iter: RTL
=============

// Module: mdu_iter
// PURPOSE
//  Parametrised iterative multiply/divide unit with HI/LO result registers.
//  Sits beside the single-cycle ALU in EX. It executes MIPS mult/multu/div/divu/mthi/mtlo.
//  Operations are launched by a start pulse. Busy/done report progress to hazard control; hi/lo feed mfhi/mflo.
// PARAMETERS
//  WIDTH    32  operand width; hi and lo are WIDTH bits each
//  MUL_LAT  4   multiply latency in cycles (>=1)
// PORTS
//  clk     in   1      clock; all state updates on rising edge
//  rst_n   in   1      asynchronous reset, active-low
//  start   in   1      launch op; sampled only when busy==0
//  op      in   4      operation code (mdu_defs.vh)
//  src_a   in   WIDTH  rs operand / dividend / multiplicand
//  src_b   in   WIDTH  rt operand / divisor / multiplier
//  flush   in   1      abort in-flight op (pipeline flush)
//  busy    out  1      op in flight; stall mfhi/mflo/new md ops
//  done    out  1      one-cycle pulse when hi/lo updated by mul/div
//  hi      out  WIDTH  HI register
//  lo      out  WIDTH  LO register
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, hi=0, lo=0. Reset takes effect mid-operation immediately; no partial write.
//  Op codes: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 8 MADD, 9 MADDU, A MSUB, B MSUBU.
//  Any other code is ignored: no state change, busy stays 0.
//  Accept: start&&!busy at edge T latches op/src_a/src_b.
//  MTHI/MTLO: hi (resp. lo) <= src_a at T; busy stays 0; no done pulse.
//  MUL*: busy=1 from T. At T+MUL_LAT, {hi,lo} <= product, done=1, busy=0.
//    MULT: signed 2*WIDTH product. MULTU: unsigned 2*WIDTH product.
//  DIV*: busy=1 from T. DIV_PREP takes abs values and 1 cycle. DIV_ITER does WIDTH restoring
//    steps, 1 bit per cycle. DIV_FIX applies signs and takes 1 cycle.
//    At T+WIDTH+2, lo <= quotient, hi <= remainder, done=1, busy=0.
//    Signed rules: quotient negative iff operand signs differ; remainder takes the sign of the dividend.
//    Divisor==0: lo = all ones, hi = src_a. Full latency is still used.
//    DIV of -2^(WIDTH-1) by -1: lo = src_a, hi = 0. No trap.
//  FSM: IDLE -> MUL -> IDLE; IDLE -> DIV_PREP -> DIV_ITER(xWIDTH) -> DIV_FIX -> IDLE.
//    A cycle counter (clog2(WIDTH+1) bits) sequences MUL and DIV_ITER.
//  start while busy: ignored and not queued; the requester must hold it until busy==0.
//  flush: when busy, go to IDLE next edge. busy=0, done=0, hi/lo unchanged.
//    When idle, flush does nothing. flush and start in the same cycle: flush wins and the op is dropped.
//  done is never asserted in the same cycle as busy.
//  hi/lo change only at the completion edge or on MTHI/MTLO.
// CONFIGURATION
//  MDU_MADD_EN defined: MADD/MADDU/MSUB/MSUBU are legal and take MUL_LAT cycles.
//    Result {hi,lo} <= {hi,lo} +/- product, mod 2^(2*WIDTH). The old {hi,lo} value is sampled at completion.
//  MDU_MADD_EN undefined: codes 8-B are illegal and ignored. The accumulate adder is not built.
// STRUCTURE
//  mdu_defs.vh: op code defines (MDU_OP_*) and FSM state encodings; shared with the decoder and hazard unit.
//  Sub-module mdu_div_step: one combinational restoring-division step.
//    Inputs {rem, quo, divisor}; outputs next {rem, quo}. It is instantiated once in DIV_ITER.
//  Multiply: WIDTH+1-bit signed operand extension, then one registered product.
//    The MUL_LAT delay comes from the counter; no multi-stage multiplier.
// TESTING
//  Reset: hold rst_n=0 with start=1 -> busy=0, done=0, hi=lo=0 after release.
//  MULT: a=-3, b=7 -> done at T+4; hi=FFFFFFFF, lo=FFFFFFEB.
//    MULTU with the same operands -> hi=00000006, lo=FFFFFFEB.
//  DIV: a=-7, b=2 -> done at T+34; lo=FFFFFFFD, hi=FFFFFFFF.
//    DIVU: a=100, b=7 -> lo=14, hi=2.
//  Div corners: b=0, a=5 -> lo=FFFFFFFF, hi=5.
//    a=80000000, b=FFFFFFFF signed -> lo=80000000, hi=0.
//  Busy/flush: start DIV, re-assert start with MULT at T+3 -> ignored.
//    flush at T+10 -> busy=0 next edge, no done, hi/lo keep prior values.
//  MTHI a=12345678 then MADD(EN) 2*3 -> hi=12345678, lo=6 after MUL_LAT.
//    Without EN, op=8 -> busy stays 0.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
// Shared op codes, FSM states and op-class helpers for the iterative multiply/divide unit.
// MDU_MADD_EN (optional define) makes the multiply-accumulate codes 8-B legal.
package mdu_iter_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'h0,
        OP_MULTU = 4'h1,
        OP_DIV   = 4'h2,
        OP_DIVU  = 4'h3,
        OP_MTHI  = 4'h4,
        OP_MTLO  = 4'h5,
        OP_MADD  = 4'h8,
        OP_MADDU = 4'h9,
        OP_MSUB  = 4'hA,
        OP_MSUBU = 4'hB
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_PREP,
        S_DIV_ITER,
        S_DIV_FIX
    } state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
        return op inside {OP_MULT, OP_MULTU};
`endif
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] sub;
    logic             fits;

    assign shifted = {rem, quo[WIDTH-1]};
    assign fits    = shifted >= {1'b0, divisor};
    // When the divisor fits the true difference is below the divisor, so WIDTH bits hold it.
    assign sub      = shifted[WIDTH-1:0] - divisor;
    assign rem_next = fits ? sub : shifted[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit with HI/LO registers (mult/multu/div/divu/mthi/mtlo).
// Define MDU_MADD_EN to add madd/maddu/msub/msubu accumulating into {hi,lo}.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic              sgn_q;
    logic [WIDTH-1:0]  a_q, b_q, rem_q, quo_q, dvs_q, rem_nx, quo_nx;
    logic [WIDTH-1:0]  hi_q, lo_q, hi_d, lo_d, a_abs, b_abs, q_fix, r_fix;
    logic [PW-1:0]     prod_q, mul_res;
    logic signed [WIDTH:0]  ext_a, ext_b;
    logic signed [PW-1:0]   prod_d;
    logic              accept, complete, op_sgn;
`ifdef MDU_MADD_EN
    logic              acc_q, sub_q;
`endif

    assign busy   = (state_q != S_IDLE);
    assign accept = start && !busy && !flush;
    assign hi     = hi_q;
    assign lo     = lo_q;

    // Bit 0 clear selects the signed flavour of every mul/div/accumulate code.
    assign op_sgn = ~op[0];
    assign ext_a  = {op_sgn & src_a[WIDTH-1], src_a};
    assign ext_b  = {op_sgn & src_b[WIDTH-1], src_b};
    assign prod_d = PW'(ext_a) * PW'(ext_b);

    assign complete = !flush && ((state_q == S_MUL && cnt_q == '0) || state_q == S_DIV_FIX);

    mdu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mul_op(op))      state_d = S_MUL;
                else if (accept && is_div_op(op)) state_d = S_DIV_PREP;
            end
            S_MUL:      if (cnt_q == '0) state_d = S_IDLE;
            S_DIV_PREP: state_d = S_DIV_ITER;
            S_DIV_ITER: if (cnt_q == '0) state_d = S_DIV_FIX;
            S_DIV_FIX:  state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (flush && busy) state_d = S_IDLE;
    end

    always_comb begin
        a_abs = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
        b_abs = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
        q_fix = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_q : quo_q;
        r_fix = (sgn_q && a_q[WIDTH-1]) ? -rem_q : rem_q;
        if (b_q == '0) begin
            q_fix = '1;
            r_fix = a_q;
        end

        mul_res = prod_q;
`ifdef MDU_MADD_EN
        if (acc_q) mul_res = sub_q ? {hi_q, lo_q} - prod_q : {hi_q, lo_q} + prod_q;
`endif

        hi_d = hi_q;
        lo_d = lo_q;
        if (accept && op == OP_MTHI) hi_d = src_a;
        if (accept && op == OP_MTLO) lo_d = src_a;
        if (complete && state_q == S_MUL) begin
            {hi_d, lo_d} = mul_res;
        end else if (complete) begin
            hi_d = r_fix;
            lo_d = q_fix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done    <= 1'b0;
`ifdef MDU_MADD_EN
            acc_q   <= 1'b0;
            sub_q   <= 1'b0;
`endif
        end else begin
            // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done    <= complete;
            if (accept) begin
                sgn_q  <= op_sgn;
                a_q    <= src_a;
                b_q    <= src_b;
                prod_q <= prod_d;
                cnt_q  <= CW'(MUL_LAT - 1);
`ifdef MDU_MADD_EN
                acc_q  <= op[3];
                sub_q  <= op[1];
`endif
            end
            case (state_q)
                S_DIV_PREP: begin
                    rem_q <= '0;
                    quo_q <= a_abs;
                    dvs_q <= b_abs;
                    cnt_q <= CW'(WIDTH - 1);
                end
                S_DIV_ITER: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                end
                S_MUL: if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                default: ;
            endcase
        end
    end

endmodule
